// File: rtl/axi_wr_pkg.sv
// Shared types and constants for the AXI3 write-port arbiter.
// Includes the FSM state enum, fixed AW attributes, response codes and a grant-pointer helper.
package axi_wr_pkg;

    typedef enum logic [1:0] {
        IDLE = 2'd0,
        ADDR = 2'd1,
        DATA = 2'd2,
        RESP = 2'd3
    } wr_state_e;

    // Grant index width is fixed at 3 bits so AWID = {zeros, 3-bit index} for any NREQ up to 8.
    localparam int IDX_W = 3;

    localparam logic [3:0] AWCACHE_DEF = 4'b0011;
    localparam logic [2:0] AWPROT_DEF  = 3'b000;
    localparam logic [3:0] AWQOS_DEF   = 4'b0000;

    localparam logic [1:0] AXI_RESP_OKAY   = 2'b00;
    localparam logic [1:0] AXI_RESP_EXOKAY = 2'b01;
    localparam logic [1:0] AXI_RESP_SLVERR = 2'b10;
    localparam logic [1:0] AXI_RESP_DECERR = 2'b11;

    function automatic logic [IDX_W-1:0] rr_next(input logic [IDX_W-1:0] g, input int n);
        if (int'(g) + 1 >= n) return '0;
        return g + 1'b1;
    endfunction

endpackage

// File: rtl/rr_arbiter.sv
// Combinational round-robin picker: first set request at or above ptr_i, wrapping.
// Returns a one-hot grant, the grant index and a valid flag.
module rr_arbiter
    import axi_wr_pkg::*;
#(
    parameter int NREQ = 2
) (
    input  logic [NREQ-1:0]  req_i,
    input  logic [IDX_W-1:0] ptr_i,
    output logic [NREQ-1:0]  gnt_o,
    output logic [IDX_W-1:0] idx_o,
    output logic             vld_o
);

    // Outer loop walks priority order; inner loop matches the rotated slot so all indexing stays constant.
    always_comb begin
        gnt_o = '0;
        idx_o = '0;
        vld_o = 1'b0;
        for (int i = 0; i < NREQ; i++) begin
            for (int k = 0; k < NREQ; k++) begin
                if (!vld_o && req_i[k] && (k == (int'(ptr_i) + i) % NREQ)) begin
                    vld_o    = 1'b1;
                    gnt_o[k] = 1'b1;
                    idx_o    = IDX_W'(k);
                end
            end
        end
    end

endmodule

// File: rtl/axi_wr_arbiter.sv
// Shares one AXI3 master write port between NREQ requesters, one burst at a time.
// Round-robin AW grant, beat-counted W with generated WLAST, B routed back to the owner.
module axi_wr_arbiter
    import axi_wr_pkg::*;
#(
    parameter int NREQ   = 2,
    parameter int ADDR_W = 32,
    parameter int DATA_W = 64,
    parameter int ID_W   = 12
) (
    input  logic                       clk,
    input  logic                       m_axi_aresetn,
    input  logic [NREQ-1:0]            req_awvalid,
    output logic [NREQ-1:0]            req_awready,
    input  logic [NREQ*ADDR_W-1:0]     req_awaddr,
    input  logic [NREQ*8-1:0]          req_awlen,
    input  logic [NREQ*3-1:0]          req_awsize,
    input  logic [NREQ*2-1:0]          req_awburst,
    input  logic [NREQ-1:0]            req_wvalid,
    output logic [NREQ-1:0]            req_wready,
    input  logic [NREQ*DATA_W-1:0]     req_wdata,
    input  logic [NREQ*DATA_W/8-1:0]   req_wstrb,
    output logic [NREQ-1:0]            req_bvalid,
    input  logic [NREQ-1:0]            req_bready,
    output logic [1:0]                 req_bresp,
    output logic [ID_W-1:0]            m_axi_awid,
    output logic [ADDR_W-1:0]          m_axi_awaddr,
    output logic [7:0]                 m_axi_awlen,
    output logic [2:0]                 m_axi_awsize,
    output logic [1:0]                 m_axi_awburst,
    output logic                       m_axi_awlock,
    output logic [3:0]                 m_axi_awcache,
    output logic [2:0]                 m_axi_awprot,
    output logic [3:0]                 m_axi_awqos,
    output logic                       m_axi_awvalid,
    input  logic                       m_axi_awready,
    output logic [ID_W-1:0]            m_axi_wid,
    output logic [DATA_W-1:0]          m_axi_wdata,
    output logic [DATA_W/8-1:0]        m_axi_wstrb,
    output logic                       m_axi_wlast,
    output logic                       m_axi_wvalid,
    input  logic                       m_axi_wready,
    input  logic [ID_W-1:0]            m_axi_bid,
    input  logic [1:0]                 m_axi_bresp,
    input  logic                       m_axi_bvalid,
    output logic                       m_axi_bready,
    output logic                       tx_wactive,
    output logic                       tx_bwait,
    output logic [7:0]                 tx_awlen,
    output logic                       bid_err
);

    localparam int STRB_W = DATA_W / 8;

    wr_state_e          state_q, state_d;
    logic [IDX_W-1:0]   rr_q, rr_d;
    logic [IDX_W-1:0]   gnt_q, gnt_d;
    logic [7:0]         beat_q, beat_d;
    logic [ADDR_W-1:0]  awaddr_q, awaddr_d;
    logic [7:0]         awlen_q, awlen_d;
    logic [2:0]         awsize_q, awsize_d;
    logic [1:0]         awburst_q, awburst_d;
    logic               awvalid_q, awvalid_d;

    logic [NREQ-1:0][ADDR_W-1:0] awaddr_a;
    logic [NREQ-1:0][7:0]        awlen_a;
    logic [NREQ-1:0][2:0]        awsize_a;
    logic [NREQ-1:0][1:0]        awburst_a;
    logic [NREQ-1:0][DATA_W-1:0] wdata_a;
    logic [NREQ-1:0][STRB_W-1:0] wstrb_a;

    assign awaddr_a  = req_awaddr;
    assign awlen_a   = req_awlen;
    assign awsize_a  = req_awsize;
    assign awburst_a = req_awburst;
    assign wdata_a   = req_wdata;
    assign wstrb_a   = req_wstrb;

    logic [NREQ-1:0]  arb_gnt;
    logic [IDX_W-1:0] arb_idx;
    logic             arb_vld;

    rr_arbiter #(.NREQ(NREQ)) u_rr (
        .req_i (req_awvalid),
        .ptr_i (rr_q),
        .gnt_o (arb_gnt),
        .idx_o (arb_idx),
        .vld_o (arb_vld)
    );

    // AW fields come from the requester being granted now; W/B from the owner of the burst in flight.
    logic [ADDR_W-1:0] sel_awaddr;
    logic [7:0]        sel_awlen;
    logic [2:0]        sel_awsize;
    logic [1:0]        sel_awburst;
    logic              sel_wvalid;
    logic [DATA_W-1:0] sel_wdata;
    logic [STRB_W-1:0] sel_wstrb;
    logic              sel_bready;

    always_comb begin
        sel_awaddr  = '0;
        sel_awlen   = '0;
        sel_awsize  = '0;
        sel_awburst = '0;
        sel_wvalid  = 1'b0;
        sel_wdata   = '0;
        sel_wstrb   = '0;
        sel_bready  = 1'b0;
        for (int r = 0; r < NREQ; r++) begin
            if (IDX_W'(r) == arb_idx) begin
                sel_awaddr  = awaddr_a[r];
                sel_awlen   = awlen_a[r];
                sel_awsize  = awsize_a[r];
                sel_awburst = awburst_a[r];
            end
            if (IDX_W'(r) == gnt_q) begin
                sel_wvalid = req_wvalid[r];
                sel_wdata  = wdata_a[r];
                sel_wstrb  = wstrb_a[r];
                sel_bready = req_bready[r];
            end
        end
    end

    always_comb begin
        state_d      = state_q;
        rr_d         = rr_q;
        gnt_d        = gnt_q;
        beat_d       = beat_q;
        awaddr_d     = awaddr_q;
        awlen_d      = awlen_q;
        awsize_d     = awsize_q;
        awburst_d    = awburst_q;
        awvalid_d    = awvalid_q;
        req_awready  = '0;
        req_wready   = '0;
        req_bvalid   = '0;
        req_bresp    = AXI_RESP_OKAY;
        m_axi_wvalid = 1'b0;
        m_axi_wlast  = 1'b0;
        m_axi_wdata  = '0;
        m_axi_wstrb  = '0;
        m_axi_bready = 1'b0;
        bid_err      = 1'b0;
        unique case (state_q)
            IDLE: begin
                if (arb_vld) begin
                    req_awready = arb_gnt;
                    gnt_d       = arb_idx;
                    awaddr_d    = sel_awaddr;
                    awlen_d     = sel_awlen;
                    awsize_d    = sel_awsize;
                    awburst_d   = sel_awburst;
                    awvalid_d   = 1'b1;
                    state_d     = ADDR;
                end
            end
            ADDR: begin
                if (m_axi_awready) begin
                    awvalid_d = 1'b0;
                    beat_d    = '0;
                    state_d   = DATA;
                end
            end
            DATA: begin
                m_axi_wvalid = sel_wvalid;
                m_axi_wdata  = sel_wdata;
                m_axi_wstrb  = sel_wstrb;
                m_axi_wlast  = (beat_q == awlen_q);
                for (int r = 0; r < NREQ; r++)
                    req_wready[r] = (IDX_W'(r) == gnt_q) && m_axi_wready;
                if (sel_wvalid && m_axi_wready) begin
                    beat_d = beat_q + 8'd1;
                    if (m_axi_wlast) state_d = RESP;
                end
            end
            RESP: begin
                m_axi_bready = sel_bready;
                req_bresp    = m_axi_bresp;
                for (int r = 0; r < NREQ; r++)
                    req_bvalid[r] = (IDX_W'(r) == gnt_q) && m_axi_bvalid;
                // A BID mismatch is flagged but the burst still retires normally.
                if (m_axi_bvalid && sel_bready) begin
                    bid_err = (m_axi_bid != m_axi_awid);
                    rr_d    = rr_next(gnt_q, NREQ);
                    state_d = IDLE;
                end
            end
            default: state_d = IDLE;
        endcase
    end

    always_ff @(posedge clk or negedge m_axi_aresetn) begin
        if (!m_axi_aresetn) begin
            state_q   <= IDLE;
            rr_q      <= '0;
            gnt_q     <= '0;
            beat_q    <= '0;
            awaddr_q  <= '0;
            awlen_q   <= '0;
            awsize_q  <= '0;
            awburst_q <= '0;
            awvalid_q <= 1'b0;
        end else begin
            state_q   <= state_d;
            rr_q      <= rr_d;
            gnt_q     <= gnt_d;
            beat_q    <= beat_d;
            awaddr_q  <= awaddr_d;
            awlen_q   <= awlen_d;
            awsize_q  <= awsize_d;
            awburst_q <= awburst_d;
            awvalid_q <= awvalid_d;
        end
    end

    assign m_axi_awid    = {{(ID_W-IDX_W){1'b0}}, gnt_q};
    assign m_axi_wid     = m_axi_awid;
    assign m_axi_awaddr  = awaddr_q;
    assign m_axi_awlen   = awlen_q;
    assign m_axi_awsize  = awsize_q;
    assign m_axi_awburst = awburst_q;
    assign m_axi_awvalid = awvalid_q;
    assign m_axi_awlock  = 1'b0;
    assign m_axi_awcache = AWCACHE_DEF;
    assign m_axi_awprot  = AWPROT_DEF;
    assign m_axi_awqos   = AWQOS_DEF;

    assign tx_wactive = (state_q == DATA);
    assign tx_bwait   = (state_q == RESP);
    assign tx_awlen   = awlen_q;

endmodule

// File: tb/tb_axi_wr_arbiter.sv
// Directed scoreboard bench for axi_wr_arbiter: expected AW/W/B items are queued when a burst
// is posted and popped as the master port and requester B ports produce them.
module tb_axi_wr_arbiter;

    localparam int NREQ   = 2;
    localparam int ADDR_W = 32;
    localparam int DATA_W = 64;
    localparam int ID_W   = 12;

    logic                     clk = 1'b0;
    logic                     m_axi_aresetn = 1'b0;
    logic [NREQ-1:0]          req_awvalid = '0;
    logic [NREQ-1:0]          req_awready;
    logic [NREQ*ADDR_W-1:0]   req_awaddr = '0;
    logic [NREQ*8-1:0]        req_awlen = '0;
    logic [NREQ*3-1:0]        req_awsize = '0;
    logic [NREQ*2-1:0]        req_awburst = '0;
    logic [NREQ-1:0]          req_wvalid = '0;
    logic [NREQ-1:0]          req_wready;
    logic [NREQ*DATA_W-1:0]   req_wdata = '0;
    logic [NREQ*DATA_W/8-1:0] req_wstrb = '0;
    logic [NREQ-1:0]          req_bvalid;
    logic [NREQ-1:0]          req_bready = '0;
    logic [1:0]               req_bresp;
    logic [ID_W-1:0]          m_axi_awid;
    logic [ADDR_W-1:0]        m_axi_awaddr;
    logic [7:0]               m_axi_awlen;
    logic [2:0]               m_axi_awsize;
    logic [1:0]               m_axi_awburst;
    logic                     m_axi_awlock;
    logic [3:0]               m_axi_awcache;
    logic [2:0]               m_axi_awprot;
    logic [3:0]               m_axi_awqos;
    logic                     m_axi_awvalid;
    logic                     m_axi_awready = 1'b0;
    logic [ID_W-1:0]          m_axi_wid;
    logic [DATA_W-1:0]        m_axi_wdata;
    logic [DATA_W/8-1:0]      m_axi_wstrb;
    logic                     m_axi_wlast;
    logic                     m_axi_wvalid;
    logic                     m_axi_wready = 1'b0;
    logic [ID_W-1:0]          m_axi_bid = '0;
    logic [1:0]               m_axi_bresp = '0;
    logic                     m_axi_bvalid = 1'b0;
    logic                     m_axi_bready;
    logic                     tx_wactive;
    logic                     tx_bwait;
    logic [7:0]               tx_awlen;
    logic                     bid_err;

    axi_wr_arbiter #(.NREQ(NREQ), .ADDR_W(ADDR_W), .DATA_W(DATA_W), .ID_W(ID_W)) dut (
        .clk(clk), .m_axi_aresetn(m_axi_aresetn),
        .req_awvalid(req_awvalid), .req_awready(req_awready), .req_awaddr(req_awaddr),
        .req_awlen(req_awlen), .req_awsize(req_awsize), .req_awburst(req_awburst),
        .req_wvalid(req_wvalid), .req_wready(req_wready), .req_wdata(req_wdata), .req_wstrb(req_wstrb),
        .req_bvalid(req_bvalid), .req_bready(req_bready), .req_bresp(req_bresp),
        .m_axi_awid(m_axi_awid), .m_axi_awaddr(m_axi_awaddr), .m_axi_awlen(m_axi_awlen),
        .m_axi_awsize(m_axi_awsize), .m_axi_awburst(m_axi_awburst), .m_axi_awlock(m_axi_awlock),
        .m_axi_awcache(m_axi_awcache), .m_axi_awprot(m_axi_awprot), .m_axi_awqos(m_axi_awqos),
        .m_axi_awvalid(m_axi_awvalid), .m_axi_awready(m_axi_awready),
        .m_axi_wid(m_axi_wid), .m_axi_wdata(m_axi_wdata), .m_axi_wstrb(m_axi_wstrb),
        .m_axi_wlast(m_axi_wlast), .m_axi_wvalid(m_axi_wvalid), .m_axi_wready(m_axi_wready),
        .m_axi_bid(m_axi_bid), .m_axi_bresp(m_axi_bresp), .m_axi_bvalid(m_axi_bvalid),
        .m_axi_bready(m_axi_bready),
        .tx_wactive(tx_wactive), .tx_bwait(tx_bwait), .tx_awlen(tx_awlen), .bid_err(bid_err)
    );

    always #5 clk = ~clk;

    initial begin
        #1000000;
        $display("FAIL watchdog: simulation time limit reached");
        $fatal(1, "watchdog");
    end

    typedef struct { int id; logic [31:0] addr; logic [7:0] len; } aw_t;
    typedef struct { logic [63:0] data; logic [7:0] strb; logic last; } w_t;
    typedef struct { int r; logic [1:0] resp; logic berr; } b_t;

    aw_t aw_q[$];
    w_t  w_q[$];
    b_t  b_q[$];

    int checks = 0;
    int failures = 0;

    int          pend[NREQ];
    int          qtx[NREQ];
    int          txn[NREQ];
    int          wb[NREQ];
    bit          inflight[NREQ];
    logic [31:0] raddr[NREQ];
    logic [7:0]  rlen[NREQ];

    int         aw_delay = 0;
    int         b_delay = 0;
    bit         w_toggle = 0;
    bit         bad_bid = 0;
    logic [1:0] slave_resp = 2'b00;

    task automatic chk(input string tag, input logic [63:0] obs, input logic [63:0] exp);
        checks++;
        assert (obs === exp) else begin
            failures++;
            $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
        end
    endtask

    function automatic logic [63:0] pat(input int r, input int t, input int beat);
        return {8'(r), 8'(t), 16'(beat), 32'hC0DE0000 | 32'(beat)};
    endfunction

    function automatic logic [7:0] strb_of(input int r);
        return (r == 0) ? 8'h0F : 8'hF0;
    endfunction

    task automatic post(input int r, input logic [31:0] a, input logic [7:0] l);
        aw_q.push_back('{id: r, addr: a, len: l});
        for (int b = 0; b <= int'(l); b++)
            w_q.push_back('{data: pat(r, qtx[r], b), strb: strb_of(r), last: (b == int'(l))});
        b_q.push_back('{r: r, resp: slave_resp, berr: bad_bid});
        raddr[r] = a;
        rlen[r]  = l;
        pend[r]++;
        qtx[r]++;
    endtask

    function automatic bit busy();
        bit any = (aw_q.size() != 0) || (w_q.size() != 0) || (b_q.size() != 0);
        for (int r = 0; r < NREQ; r++) if (pend[r] > 0 || inflight[r]) any = 1'b1;
        return any;
    endfunction

    task automatic clear_model();
        aw_q.delete(); w_q.delete(); b_q.delete();
        for (int r = 0; r < NREQ; r++) begin
            pend[r] = 0; qtx[r] = 0; txn[r] = 0; wb[r] = 0; inflight[r] = 0;
        end
        req_awvalid = '0; req_wvalid = '0; req_bready = '0;
        m_axi_awready = 1'b0; m_axi_wready = 1'b0; m_axi_bvalid = 1'b0;
    endtask

    // Cycle engine: drive at negedge, sample #1 later, stop when everything queued has drained.
    task automatic run(input int budget, input int abort_beats, input int exp_beats);
        int cyc = 0;
        int nbeats = 0;
        int aw_wait = 0;
        int b_wait = 0;
        bit b_pend = 0;
        bit aw_acc = 0;
        bit hold = 0;
        logic [ID_W-1:0] s_awid = '0;
        logic [31:0] h_addr = '0;
        logic [7:0] h_len = '0;
        logic [ID_W-1:0] h_id = '0;
        logic [7:0] cur_len = '0;
        while (busy() && cyc < budget) begin
            @(negedge clk);
            cyc++;
            for (int r = 0; r < NREQ; r++) begin
                req_awvalid[r] = (pend[r] > 0);
                req_awaddr[r*ADDR_W +: ADDR_W] = raddr[r];
                req_awlen[r*8 +: 8] = rlen[r];
                req_awsize[r*3 +: 3] = 3'd3;
                req_awburst[r*2 +: 2] = 2'd1;
                req_wvalid[r] = inflight[r];
                req_wdata[r*DATA_W +: DATA_W] = pat(r, txn[r], wb[r]);
                req_wstrb[r*8 +: 8] = strb_of(r);
                req_bready[r] = 1'b1;
            end
            m_axi_awready = m_axi_awvalid && (aw_wait >= aw_delay);
            m_axi_wready  = w_toggle ? (cyc % 2 == 0) : 1'b1;
            m_axi_bvalid  = b_pend && (b_wait >= b_delay);
            m_axi_bid     = bad_bid ? (s_awid ^ ID_W'(1)) : s_awid;
            m_axi_bresp   = slave_resp;
            #1;
            if (m_axi_awvalid) begin
                if (hold) begin
                    chk("aw_addr_stable", 64'(m_axi_awaddr), 64'(h_addr));
                    chk("aw_len_stable", 64'(m_axi_awlen), 64'(h_len));
                    chk("aw_id_stable", 64'(m_axi_awid), 64'(h_id));
                end
                if (m_axi_awready) begin
                    if (aw_q.size() == 0) chk("aw_unexpected", 64'(1), 64'(0));
                    else begin
                        aw_t e = aw_q.pop_front();
                        chk("awid", 64'(m_axi_awid), 64'(e.id));
                        chk("awaddr", 64'(m_axi_awaddr), 64'(e.addr));
                        chk("awlen", 64'(m_axi_awlen), 64'(e.len));
                        chk("awsize_burst", 64'({m_axi_awsize, m_axi_awburst}), 64'({3'd3, 2'd1}));
                        chk("aw_fixed", 64'({m_axi_awlock, m_axi_awcache, m_axi_awprot, m_axi_awqos}),
                            64'({1'b0, 4'b0011, 3'b000, 4'b0000}));
                        cur_len = e.len;
                    end
                    s_awid = m_axi_awid;
                    aw_acc = 1'b1;
                    hold = 1'b0;
                    aw_wait = 0;
                end else begin
                    hold = 1'b1;
                    h_addr = m_axi_awaddr; h_len = m_axi_awlen; h_id = m_axi_awid;
                    aw_wait++;
                end
            end
            if (b_pend && !m_axi_bvalid) b_wait++;
            if (m_axi_wvalid) chk("w_after_aw", 64'(aw_acc), 64'(1));
            if (m_axi_wvalid && m_axi_wready) begin
                nbeats++;
                if (w_q.size() == 0) chk("w_unexpected", 64'(1), 64'(0));
                else begin
                    w_t e = w_q.pop_front();
                    chk("wdata", m_axi_wdata, e.data);
                    chk("wstrb", 64'(m_axi_wstrb), 64'(e.strb));
                    chk("wlast", 64'(m_axi_wlast), 64'(e.last));
                end
                chk("wid", 64'(m_axi_wid), 64'(s_awid));
                chk("tx_awlen", 64'(tx_awlen), 64'(cur_len));
                if (m_axi_wlast) begin
                    b_pend = 1'b1; b_wait = 0; aw_acc = 1'b0;
                end
            end
            if (m_axi_bvalid && m_axi_bready) begin
                if (b_q.size() == 0) chk("b_unexpected", 64'(1), 64'(0));
                else begin
                    b_t e = b_q.pop_front();
                    logic [NREQ-1:0] oh = '0;
                    oh[e.r] = 1'b1;
                    chk("req_bvalid", 64'(req_bvalid), 64'(oh));
                    chk("req_bresp", 64'(req_bresp), 64'(e.resp));
                    chk("bid_err", 64'(bid_err), 64'(e.berr));
                end
                b_pend = 1'b0;
            end else begin
                chk("bid_err_idle", 64'(bid_err), 64'(0));
            end
            for (int r = 0; r < NREQ; r++) begin
                if (req_awvalid[r] && req_awready[r]) begin
                    pend[r]--; inflight[r] = 1'b1; wb[r] = 0;
                end
                if (req_wvalid[r] && req_wready[r]) begin
                    wb[r]++;
                    if (wb[r] == int'(rlen[r]) + 1) inflight[r] = 1'b0;
                end
                if (req_bvalid[r] && req_bready[r]) txn[r]++;
            end
            if (abort_beats > 0 && nbeats == abort_beats) break;
        end
        chk("within_budget", 64'(cyc < budget), 64'(1));
        chk("beat_count", 64'(nbeats), 64'(exp_beats));
    endtask

    task automatic idle_chk(input string tag);
        @(negedge clk);
        #1;
        chk({tag, "_idle"}, 64'({tx_wactive, tx_bwait, m_axi_awvalid, m_axi_wvalid, m_axi_bready}), 64'(0));
    endtask

    task automatic zero_chk(input string tag);
        chk({tag, "_ctl"}, 64'({m_axi_awvalid, m_axi_wvalid, m_axi_wlast, m_axi_bready, tx_wactive, tx_bwait, bid_err}), 64'(0));
        chk({tag, "_req"}, 64'({req_awready, req_wready, req_bvalid}), 64'(0));
        chk({tag, "_awid"}, 64'(m_axi_awid), 64'(0));
        chk({tag, "_awaddr"}, 64'(m_axi_awaddr), 64'(0));
        chk({tag, "_awlen"}, 64'({m_axi_awlen, tx_awlen}), 64'(0));
    endtask

    initial begin
        clear_model();
        for (int r = 0; r < NREQ; r++) begin raddr[r] = '0; rlen[r] = '0; end
        #12;
        zero_chk("reset");
        @(negedge clk);
        m_axi_aresetn = 1'b1;

        // Single 4-beat burst from requester 0
        aw_delay = 0; b_delay = 0; w_toggle = 0; bad_bid = 0; slave_resp = 2'b00;
        post(0, 32'h1000, 8'd3);
        run(50, 0, 4);
        idle_chk("single");

        // BID mismatch on requester 1: error flagged, response still delivered
        bad_bid = 1; slave_resp = 2'b00;
        post(1, 32'h2000, 8'd1);
        run(50, 0, 2);
        idle_chk("bid");
        bad_bid = 0;

        // Contention: both requesters hold awvalid, grants must alternate 0,1,0,1
        slave_resp = 2'b01;
        post(0, 32'h3000, 8'd0);
        post(1, 32'h3100, 8'd0);
        post(0, 32'h3000, 8'd0);
        post(1, 32'h3100, 8'd0);
        run(100, 0, 4);
        idle_chk("contend");

        // Backpressure on all three slave channels
        aw_delay = 5; b_delay = 3; w_toggle = 1; slave_resp = 2'b10;
        post(0, 32'h4000, 8'd7);
        run(100, 0, 8);
        idle_chk("bp");

        // Maximum burst length
        aw_delay = 0; b_delay = 0; w_toggle = 0; slave_resp = 2'b00;
        post(1, 32'h5000, 8'd255);
        run(400, 0, 256);
        idle_chk("max");

        // Reset mid-DATA after 2 of 4 beats
        post(0, 32'h6000, 8'd3);
        run(50, 2, 2);
        @(posedge clk);
        #2;
        m_axi_aresetn = 1'b0;
        clear_model();
        #1;
        zero_chk("midrst");
        repeat (2) @(negedge clk);
        zero_chk("midrst_hold");
        m_axi_aresetn = 1'b1;

        // Fresh burst after reset must go to requester 1 and complete normally
        post(1, 32'h7000, 8'd3);
        run(50, 0, 4);
        idle_chk("post_rst");

        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

endmodule
